// File: rtl/ifetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and memory (slave).
//
// Handshake: the master raises imem_req with imem_addr and holds both stable
// until the slave answers; a transfer completes on every rising edge where
// imem_req=1 and imem_ack=1, and imem_rdata is only meaningful at that edge.
// The slave must tolerate imem_req dropping without an ack (reset abort).
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: takes a pc from the control FSM, runs one
// req/ack transfer on the instruction-memory bus and latches the word into
// the instruction register. Flags misaligned pc and memory timeout (sticky
// until err_clr) and supports redirect flushes.
//
// Optional macro IFETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt.
// TIMEOUT_CYCLES must lie in 2..255 (the wait counter is 8 bits wide).
module ifetch_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] RESET_IR       = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_start,
    input  logic [31:0]          pc,
    input  logic                 flush,
    input  logic                 err_clr,
    output logic                 fetch_ready,
    ifetch_unit_if.master        mem,
    output logic [31:0]          ir,
    output logic [31:0]          ir_pc,
    output logic                 ir_valid,
    output logic                 fetch_done,
    output logic                 addr_err,
    output logic                 timeout_err,
    output logic [1:0]           fsm_state
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Last counter value at which a missing ack turns into a timeout.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  wait_cnt;
    logic        discard;

    logic        start_ok;
    logic        misaligned;
    logic        ack_hit;
    logic        drop;
    logic        timeout_hit;
    logic        load_ir;

    assign fsm_state = state;

    // Decode of the current cycle: accepted start, completed transfer, timeout.
    always_comb begin
        fetch_ready = (state == IDLE) || (state == DONE);
        start_ok    = fetch_ready && fetch_start;
        misaligned  = (pc[1:0] != 2'b00);
        ack_hit     = (state == BUSY) && mem.imem_req && mem.imem_ack;
        // A flush arriving on the ack edge itself also discards the data.
        drop        = discard || flush;
        timeout_hit = (state == BUSY) && !mem.imem_ack && (wait_cnt >= TIMEOUT_LAST);
        load_ir     = ack_hit && !drop;
    end

    // Next-state logic; an ack on the final counting cycle beats the timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_next = misaligned ? ERR : BUSY;
                end else if ((state == DONE) && flush) begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                if (ack_hit) begin
                    state_next = drop ? IDLE : DONE;
                end else if (timeout_hit) begin
                    state_next = ERR;
                end
            end
            ERR: begin
                if (err_clr) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, bus outputs, instruction register and sticky errors.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            mem.imem_req  <= 1'b0;
            mem.imem_addr <= 32'h0;
            wait_cnt      <= 8'd0;
            discard       <= 1'b0;
            ir            <= RESET_IR;
            ir_pc         <= 32'h0;
            ir_valid      <= 1'b0;
            fetch_done    <= 1'b0;
            addr_err      <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            state        <= state_next;
            // Request is high exactly while the FSM sits in BUSY.
            mem.imem_req <= (state_next == BUSY);
            fetch_done   <= load_ir;

            if (start_ok && !misaligned) begin
                mem.imem_addr <= pc;
                wait_cnt      <= 8'd0;
                discard       <= 1'b0;
            end else if (state == BUSY) begin
                if (flush) begin
                    discard <= 1'b1;
                end
                // Saturating: the counter never wraps back to zero.
                if (!mem.imem_ack && (wait_cnt != 8'hFF)) begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end

            if (load_ir) begin
                ir    <= mem.imem_rdata;
                ir_pc <= mem.imem_addr;
            end

            if (load_ir) begin
                ir_valid <= 1'b1;
            end else if (start_ok) begin
                ir_valid <= 1'b0;
            end else if ((state == DONE) && flush) begin
                ir_valid <= 1'b0;
            end

            if (start_ok && misaligned) begin
                addr_err <= 1'b1;
            end else if ((state == ERR) && err_clr) begin
                addr_err <= 1'b0;
            end

            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if ((state == ERR) && err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

`ifdef IFETCH_PERF_EN
    // Performance counters: completed fetches and BUSY cycles spent waiting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetch_cnt <= 32'h0;
            perf_stall_cnt <= 32'h0;
        end else begin
            if (load_ir) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if ((state == BUSY) && !mem.imem_ack) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
